// File: rtl/float32_pkg.sv
// Shared types, constants and the operand unpacker for the multi-cycle
// binary32 adder.
package float32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic [2:0] ST_NONE     = 3'd0;
  localparam logic [2:0] ST_OK       = 3'd1;
  localparam logic [2:0] ST_INEXACT  = 3'd2;
  localparam logic [2:0] ST_OVERFLOW = 3'd3;
  localparam logic [2:0] ST_INVALID  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM_RND
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;   // effective exponent: subnormals report 1
    logic [MAN_W:0]   sig;   // significand including hidden bit
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
  } fp_unpacked_t;

  function automatic fp_unpacked_t unpack(input logic [31:0] x);
    fp_unpacked_t     u;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e         = x[30:23];
    f         = x[22:0];
    u.sign    = x[31];
    u.exp     = (e == '0) ? 8'd1 : e;
    u.sig     = {(e != '0), f};
    u.is_nan  = (e == '1) && (f != '0);
    u.is_inf  = (e == '1) && (f == '0);
    u.is_zero = (e == '0) && (f == '0);
    return u;
  endfunction

endpackage

// File: rtl/float32_lzc.sv
// Combinational leading-zero counter over the 28-bit raw significand sum.
module float32_lzc (
  input  logic [27:0] value,
  output logic [4:0]  count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/float32_add.sv
// Four-cycle binary32 adder/subtractor, round-to-nearest-even, full subnormal
// support, with a load/busy handshake for a polling controller.
module float32_add
  import float32_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] leftArg,
  input  logic [31:0] rightArg,
  input  logic        addSub,
  input  logic        loadArgs,
  output logic [2:0]  status,
  output logic        busy,
  output logic [31:0] sum
);

  state_e       state_q, state_d;
  logic [31:0]  a_q, a_d, b_q, b_d;
  logic         add_q, add_d;
  fp_unpacked_t ua_q, ua_d, ub_q, ub_d;
  logic [26:0]  big_q, big_d, small_q, small_d;
  logic [9:0]   exp_q, exp_d;
  logic         sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic         spec_q, spec_d;
  logic [31:0]  spec_sum_q, spec_sum_d;
  logic [2:0]   spec_st_q, spec_st_d;
  logic [27:0]  raw_q, raw_d;
  logic [31:0]  sum_q, sum_d;
  logic [2:0]   status_q, status_d;

  // Alignment: larger magnitude becomes the reference operand.
  fp_unpacked_t big_op, small_op;
  logic [7:0]   diff;
  logic [26:0]  small_ext, shifted, lost;

  always_comb begin
    if ({ua_q.exp, ua_q.sig} >= {ub_q.exp, ub_q.sig}) begin
      big_op   = ua_q;
      small_op = ub_q;
    end else begin
      big_op   = ub_q;
      small_op = ua_q;
    end
    diff      = big_op.exp - small_op.exp;
    small_ext = {small_op.sig, 3'b000};
    shifted   = small_ext >> diff;
    lost      = small_ext & ~({27{1'b1}} << diff);
  end

  // Normalise and round the registered raw sum.
  logic [4:0]  lz;
  logic [27:0] norm;
  logic [9:0]  exp_n, lshift, exp_f;
  logic [24:0] mant_r;
  logic        guard, rnd_sticky, round_up;
  logic [22:0] frac;
  logic [31:0] res_sum;
  logic [2:0]  res_st;

  float32_lzc u_lzc (
    .value (raw_q),
    .count (lz)
  );

  always_comb begin
    norm   = raw_q;
    exp_n  = exp_q;
    lshift = '0;
    if (raw_q[27]) begin
      norm  = {1'b0, raw_q[27:2], raw_q[1] | raw_q[0]};
      exp_n = exp_q + 10'd1;
    end else begin
      // Never shift below the subnormal boundary (effective exponent 1).
      lshift = {5'd0, lz} - 10'd1;
      if (lshift > exp_q - 10'd1) lshift = exp_q - 10'd1;
      norm  = raw_q << lshift;
      exp_n = exp_q - lshift;
    end
    guard      = norm[2];
    rnd_sticky = norm[1] | norm[0];
    round_up   = guard & (rnd_sticky | norm[3]);
    mant_r     = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mant_r[24]) begin
      exp_f = exp_n + 10'd1;
      frac  = mant_r[23:1];
    end else begin
      exp_f = mant_r[23] ? exp_n : 10'd0;
      frac  = mant_r[22:0];
    end

    if (spec_q) begin
      res_sum = spec_sum_q;
      res_st  = spec_st_q;
    end else if (raw_q == '0) begin
      res_sum = 32'h0000_0000;
      res_st  = ST_OK;
    end else if (exp_f >= 10'd255) begin
      res_sum = {sign_q, 8'hFF, 23'd0};
      res_st  = ST_OVERFLOW;
    end else begin
      res_sum = {sign_q, exp_f[7:0], frac};
      res_st  = (guard | rnd_sticky) ? ST_INEXACT : ST_OK;
    end
  end

  // NOTE: every always_comb target gets a default (hold) first, so no path
  // can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    add_d      = add_q;
    ua_d       = ua_q;
    ub_d       = ub_q;
    big_d      = big_q;
    small_d    = small_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    eff_sub_d  = eff_sub_q;
    spec_d     = spec_q;
    spec_sum_d = spec_sum_q;
    spec_st_d  = spec_st_q;
    raw_d      = raw_q;
    sum_d      = sum_q;
    status_d   = status_q;

    unique case (state_q)
      S_IDLE: begin
        if (loadArgs) begin
          a_d     = leftArg;
          b_d     = rightArg;
          add_d   = addSub;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        ua_d      = unpack(a_q);
        ub_d      = unpack(b_q);
        ub_d.sign = b_q[31] ^ ~add_q;
        state_d   = S_ALIGN;
      end
      S_ALIGN: begin
        big_d     = {big_op.sig, 3'b000};
        small_d   = (diff >= 8'd26) ? {26'd0, |small_op.sig}
                                    : {shifted[26:1], shifted[0] | (|lost)};
        exp_d     = {2'b00, big_op.exp};
        sign_d    = big_op.sign;
        eff_sub_d = big_op.sign ^ small_op.sign;

        spec_d     = 1'b1;
        spec_st_d  = ST_OK;
        spec_sum_d = QNAN;
        if (ua_q.is_nan || ub_q.is_nan ||
            (ua_q.is_inf && ub_q.is_inf && (ua_q.sign != ub_q.sign))) begin
          spec_st_d = ST_INVALID;
        end else if (ua_q.is_inf) begin
          spec_sum_d = {ua_q.sign, 8'hFF, 23'd0};
        end else if (ub_q.is_inf) begin
          spec_sum_d = {ub_q.sign, 8'hFF, 23'd0};
        end else if (ua_q.is_zero && ub_q.is_zero) begin
          spec_sum_d = {ua_q.sign & ub_q.sign, 31'd0};
        end else begin
          spec_d = 1'b0;
        end
        state_d = S_ADD;
      end
      S_ADD: begin
        raw_d   = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                            : ({1'b0, big_q} + {1'b0, small_q});
        state_d = S_NORM_RND;
      end
      S_NORM_RND: begin
        sum_d    = res_sum;
        status_d = res_st;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      sum_q    <= '0;
      status_q <= ST_NONE;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      status_q <= status_d;
    end
  end

  // NOTE: pipeline datapath flops carry no reset; every one is written by
  // its stage before any later stage reads it.
  always_ff @(posedge CLK) begin
    a_q        <= a_d;
    b_q        <= b_d;
    add_q      <= add_d;
    ua_q       <= ua_d;
    ub_q       <= ub_d;
    big_q      <= big_d;
    small_q    <= small_d;
    exp_q      <= exp_d;
    sign_q     <= sign_d;
    eff_sub_q  <= eff_sub_d;
    spec_q     <= spec_d;
    spec_sum_q <= spec_sum_d;
    spec_st_q  <= spec_st_d;
    raw_q      <= raw_d;
  end

  assign busy   = (state_q != S_IDLE);
  assign sum    = sum_q;
  assign status = status_q;

endmodule

// File: tb/tb_float32_add.sv
// Directed bench for float32_add: reset, latency, arithmetic vectors,
// ignored loads, back-to-back loads and mid-operation reset.
module tb_float32_add;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] leftArg, rightArg;
  logic        addSub, loadArgs;
  logic [2:0]  status;
  logic        busy;
  logic [31:0] sum;

  int total = 0;
  int bad   = 0;

  float32_add dut (
    .CLK      (CLK),
    .RST      (RST),
    .leftArg  (leftArg),
    .rightArg (rightArg),
    .addSub   (addSub),
    .loadArgs (loadArgs),
    .status   (status),
    .busy     (busy),
    .sum      (sum)
  );

  always #5 CLK = ~CLK;

  localparam int NV = 16;
  localparam logic [31:0] VA [NV] = '{
    32'h3F800000, 32'h40400000, 32'h3F800001, 32'h3F800000,
    32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h80000000,
    32'h80000000, 32'h3F800000, 32'h3F800000, 32'h7FC00001,
    32'h00800000, 32'h00400000, 32'h7F800000, 32'hC0000000};
  localparam logic [31:0] VB [NV] = '{
    32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h33800000,
    32'h33800000, 32'h7F7FFFFF, 32'hFF800000, 32'h80000000,
    32'h00000000, 32'h3F800000, 32'hFF800000, 32'h3F800000,
    32'h00000001, 32'h00400000, 32'h7F800000, 32'h3F800000};
  localparam logic VOP [NV] = '{
    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] VS [NV] = '{
    32'h40000000, 32'h40000000, 32'h34000000, 32'h3F800000,
    32'h3F800002, 32'h7F800000, 32'h7FC00000, 32'h80000000,
    32'h80000000, 32'h00000000, 32'hFF800000, 32'h7FC00000,
    32'h007FFFFF, 32'h00800000, 32'h7FC00000, 32'hBF800000};
  localparam logic [2:0] VST [NV] = '{
    3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd1,
    3'd1, 3'd1, 3'd1, 3'd4, 3'd1, 3'd1, 3'd4, 3'd1};

  // Called at a falling edge; returns at the falling edge after the load edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic op);
    leftArg  = a;
    rightArg = b;
    addSub   = op;
    loadArgs = 1'b1;
    @(negedge CLK);
    loadArgs = 1'b0;
  endtask

  // Bounded wait for busy to drop; reports falling edges waited.
  task automatic wait_done(output int cycles, output logic timed_out);
    cycles    = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge CLK);
      cycles++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; loadArgs = 1'b0; addSub = 1'b1; leftArg = '0; rightArg = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    total++;
    if (busy !== 1'b0 || sum !== 32'h0 || status !== 3'd0) begin
      bad++;
      $display("FAIL reset: busy=%b sum=%h status=%0d, need busy=0 sum=00000000 status=0",
               busy, sum, status);
    end
  endtask

  task automatic test_subnormal();
    launch(32'h000000F3, 32'h00013F72, 1'b1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL subnormal busy cycle %0d: busy=%b, need 1", i + 1, busy);
      end
      @(negedge CLK);
    end
    total++;
    if (busy !== 1'b0 || sum !== 32'h00014065 || status !== 3'd1) begin
      bad++;
      $display("FAIL subnormal result: busy=%b sum=%h status=%0d, need busy=0 sum=00014065 status=1",
               busy, sum, status);
    end
  endtask

  task automatic test_vectors();
    int   cyc;
    logic to;
    for (int v = 0; v < NV; v++) begin
      launch(VA[v], VB[v], VOP[v]);
      wait_done(cyc, to);
      total++;
      if (to || cyc != 4) begin
        bad++;
        $display("FAIL vec%0d latency: waited=%0d timeout=%b, need 4", v, cyc, to);
      end
      total++;
      if (sum !== VS[v] || status !== VST[v]) begin
        bad++;
        $display("FAIL vec%0d %h %s %h: sum=%h status=%0d, need sum=%h status=%0d",
                 v, VA[v], VOP[v] ? "+" : "-", VB[v], sum, status, VS[v], VST[v]);
      end
    end
  endtask

  task automatic test_ignore_load();
    int   cyc;
    logic to;
    launch(32'h3F800000, 32'h40000000, 1'b1);
    leftArg  = 32'h7F800000;
    rightArg = 32'hFF800000;
    addSub   = 1'b0;
    loadArgs = 1'b1;
    repeat (3) @(negedge CLK);
    loadArgs = 1'b0;
    wait_done(cyc, to);
    total++;
    if (to || sum !== 32'h40400000 || status !== 3'd1) begin
      bad++;
      $display("FAIL ignore_load: sum=%h status=%0d timeout=%b, need sum=40400000 status=1",
               sum, status, to);
    end
    repeat (2) @(negedge CLK);
    total++;
    if (busy !== 1'b0 || sum !== 32'h40400000) begin
      bad++;
      $display("FAIL ignore_load retrigger: busy=%b sum=%h, need busy=0 sum=40400000", busy, sum);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    leftArg  = 32'h40000000;
    rightArg = 32'h40000000;
    addSub   = 1'b1;
    loadArgs = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge CLK);
      total++;
      if (busy !== ((j % 5) != 4)) begin
        bad++;
        $display("FAIL back_to_back busy after edge %0d: busy=%b, need %b",
                 j, busy, ((j % 5) != 4));
      end
      if ((j % 5) == 4) begin
        done_cnt++;
        total++;
        if (sum !== 32'h40800000 || status !== 3'd1) begin
          bad++;
          $display("FAIL back_to_back result %0d: sum=%h status=%0d, need 40800000 status=1",
                   done_cnt, sum, status);
        end
      end
    end
    loadArgs = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    launch(32'h3F800000, 32'h3F800000, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    total++;
    if (busy !== 1'b0 || sum !== 32'h0 || status !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b sum=%h status=%0d, need busy=0 sum=00000000 status=0",
               busy, sum, status);
    end
    repeat (6) @(negedge CLK);
    total++;
    if (busy !== 1'b0 || sum !== 32'h0 || status !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid late completion: busy=%b sum=%h status=%0d, need 0/00000000/0",
               busy, sum, status);
    end
  endtask

  initial begin
    RST = 1'b1;
    @(negedge CLK);
    test_reset();
    test_subnormal();
    test_vectors();
    test_ignore_load();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float32_add.md
Name: float32_add

Overview:
- Multi-cycle IEEE-754 binary32 adder/subtractor with a load/busy handshake.
- Operands are captured on a load request. The result and a 3-bit status are produced a fixed 4 cycles later.
- Used as a standalone arithmetic unit by a sequencing controller that polls busy.

Parameters:
- none (format fixed to binary32; latency fixed to 4 cycles)

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  reset, synchronous, active-high
- leftArg  in  32  operand A (binary32)
- rightArg  in  32  operand B (binary32)
- addSub  in  1  1 = A+B, 0 = A-B (B sign inverted); sampled with operands
- loadArgs  in  1  load request, level-sampled at rising edge
- status  out  3  result code for the last completed operation
- busy  out  1  high while an operation is in flight
- sum  out  32  result (binary32)

Behaviour:
- One clock; reset is synchronous and active-high (ports CLK, RST).
- Reset: on any edge with RST=1, state goes to IDLE, busy=0, sum=0x00000000, status=3'd0. RST overrides loadArgs. An in-flight operation is discarded.
- Status codes:
  - 0 NONE: no result since reset
  - 1 OK: exact result
  - 2 INEXACT: rounded
  - 3 OVERFLOW: result ±Inf from finite inputs
  - 4 INVALID: NaN result
  - 5..7 unused
  - Precedence: INVALID > OVERFLOW > INEXACT > OK.
- Handshake:
  - At edge k with busy=0 and loadArgs=1, latch leftArg, rightArg and addSub, and set busy=1.
  - At edge k+4, write sum/status and clear busy=0.
  - loadArgs while busy=1 is ignored. Operand changes while busy have no effect.
  - loadArgs held high continuously re-triggers at the first edge with busy=0, so back-to-back operations have a period of 5 cycles.
  - sum/status hold their value until the next completion or reset.
- FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM_RND -> IDLE, one state per cycle. The result is registered on the NORM_RND -> IDLE edge.
- Arithmetic:
  - Full IEEE-754 binary32 with round-to-nearest-even.
  - Subnormal inputs and outputs are fully supported; no flush-to-zero.
  - Align with guard/round/sticky bits: shifts of 26 or more collapse to sticky.
  - Significand add/sub is 27+ bits wide. Normalise with a leading-zero count. Exponent is clamped at the subnormal boundary.
  - Rounding carry may increment the exponent. Reaching exponent 255 gives ±Inf with status OVERFLOW.
- Special cases:
  - Any NaN input gives 0x7FC00000, INVALID.
  - +Inf + -Inf (effective) gives 0x7FC00000, INVALID.
  - Inf with a finite operand gives that Inf, OK.
  - Exact zero result is +0, except (-0)+(-0) and (-0)-(+0), which give -0.
  - x - x gives +0.

Decomposition:
- Package float32_pkg holds:
  - status code localparams
  - field widths: EXP_W=8, MAN_W=23, BIAS=127
  - QNAN=32'h7FC00000
  - FSM state enum
  - unpacked-operand struct: sign, exp, significand with hidden bit, is_nan, is_inf, is_zero
- One natural sub-module: float32_lzc, a combinational 28-bit leading-zero counter used by NORM_RND.

Test Plan:
- Subnormal add: reset 2 cycles, left=0x000000F3, right=0x00013F72, addSub=1, loadArgs for 1 cycle. Required: busy=1 for 4 cycles, then sum=0x00014065, status=1.
- Normal add/sub: 0x3F800000+0x3F800000 gives 0x40000000 status 1. 0x40400000 with addSub=0 minus 0x3F800000 gives 0x40000000 status 1. 0x3F800001-0x3F800000 gives 0x34000000 status 1.
- Rounding: 0x3F800000+0x33800000 gives 0x3F800000 status 2 (tie to even). 0x3F800001+0x33800000 gives 0x3F800002 status 2.
- Specials: 0x7F7FFFFF+0x7F7FFFFF gives 0x7F800000 status 3. 0x7F800000+0xFF800000 gives 0x7FC00000 status 4. 0x80000000+0x80000000 gives 0x80000000 status 1.
- Handshake: pulse loadArgs again at cycles 1–3 of busy with other operands. Required: ignored, first result unchanged. Holding loadArgs high gives completions every 5 cycles.
- Reset mid-operation: assert RST at busy cycle 2. Required: next edge busy=0, sum=0, status=0, and no later completion.
